// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared state encodings, opcodes, ALU op codes and control-word layout
package multicycle_controller_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [1:0] SRC_A_PC = 2'b00, SRC_A_OLDPC = 2'b01, SRC_A_RS1 = 2'b10;
    localparam logic [1:0] SRC_B_RS2 = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_update;
        logic       reg_write;
        logic       branch;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;
    function automatic logic is_legal(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE || op == OP_ITYPE ||
               op == OP_BRANCH || op == OP_JAL;
    endfunction
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps alu_op and instruction fields to the ALU operation select
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    assign alu_control = alu_op == ALU_OP_SUB ? ALU_SUB :
                         alu_op != ALU_OP_FUNCT ? ALU_ADD :
                         funct3 == 3'b000 ? (op5 & funct7b5 ? ALU_SUB : ALU_ADD) :
                         (funct3 == 3'b010 || funct3 == 3'b011) ? ALU_ADD : funct3;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle RV32 subset datapath
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);
    state_t state_q, next, cur;
    ctrl_t  c;
    logic   taken;
    always_ff @(posedge clk)
        state_q <= reset ? S_FETCH : next;
    always_comb begin
        next = S_FETCH;
        case (state_q)
            S_FETCH:    next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (op)
                    OP_LOAD, OP_STORE: next = S_MEMADR;
                    OP_RTYPE:          next = S_EXECUTER;
                    OP_ITYPE:          next = S_EXECUTEI;
                    OP_BRANCH:         next = S_BRANCH;
                    OP_JAL:            next = S_JAL;
                    default:           next = S_FETCH;
                endcase
            S_MEMADR:   next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: next = S_ALUWB;
            default:    next = S_FETCH;
        endcase
    end
    // under reset the outputs present FETCH values with every enable forced low
    assign cur = reset ? S_FETCH : state_q;
    always_comb begin
        c = '0;
        case (cur)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.src_b      = SRC_B_FOUR;
                c.result_src = RES_ALU;
                c.ir_write   = mem_ready;
                c.pc_update  = mem_ready;
            end
            S_DECODE: begin
                c.src_a = SRC_A_OLDPC;
                c.src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                c.src_a = SRC_A_RS1;
                c.src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.src_a  = SRC_A_RS1;
                c.alu_op = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                c.src_a  = SRC_A_RS1;
                c.src_b  = SRC_B_IMM;
                c.alu_op = ALU_OP_FUNCT;
            end
            S_ALUWB:  c.reg_write = 1'b1;
            S_BRANCH: begin
                c.src_a  = SRC_A_RS1;
                c.alu_op = ALU_OP_SUB;
                c.branch = 1'b1;
            end
            S_JAL: begin
                c.src_a     = SRC_A_OLDPC;
                c.src_b     = SRC_B_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
    end
    assign taken = (funct3 == 3'b000 & zero) | (funct3 == 3'b001 & ~zero) | (funct3 == 3'b100 & alu_lt);
    assign mem_req    = c.mem_req & ~reset;
    assign adr_src    = c.adr_src;
    assign mem_write  = c.mem_write & ~reset;
    assign ir_write   = c.ir_write & ~reset;
    assign pc_write   = (c.pc_update | (c.branch & taken)) & ~reset;
    assign reg_write  = c.reg_write & ~reset;
    assign alu_src_a  = c.src_a;
    assign alu_src_b  = c.src_b;
    assign result_src = c.result_src;
    assign imm_src    = op == OP_STORE ? 2'b01 : op == OP_BRANCH ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    assign illegal    = ~reset & (state_q == S_DECODE) & ~is_legal(op);
    assign state      = state_q;
    alu_decoder u_alu_decoder (
        .alu_op      (c.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction cycle-trace reference model versus the controller
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;
    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, zero = 1'b0, alu_lt = 1'b0, mem_ready = 1'b0;
    logic mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    int vectors = 0, miscompares = 0;
    typedef struct packed {
        logic [3:0] st;
        logic mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
        logic [1:0] sa, sb, rs, imm;
        logic [2:0] alu;
    } exp_t;
    typedef struct { exp_t e; logic rdy; logic rst; } cyc_t;
    cyc_t q[$];
    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .alu_lt(alu_lt), .mem_ready(mem_ready), .mem_req(mem_req),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
        .illegal(illegal), .state(state)
    );
    always #5 clk = ~clk;
    function automatic logic legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction
    function automatic logic [1:0] imm_of(input logic [6:0] o);
        return o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 : o == 7'b1101111 ? 2'b11 : 2'b00;
    endfunction
    function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
        if (f3 == 3'b000) return (op5 && f7) ? 3'b010 : 3'b000;
        if (f3 == 3'b010 || f3 == 3'b011) return 3'b000;
        return f3;
    endfunction
    function automatic exp_t base(input state_t s);
        exp_t e = '0;
        e.st  = s;
        e.imm = imm_of(op);
        return e;
    endfunction
    function automatic exp_t reset_exp(input state_t s);
        exp_t e = base(s);
        e.sb = 2'd2;
        e.rs = 2'd2;
        return e;
    endfunction
    function automatic void push(input exp_t e, input logic rdy, input logic rst = 1'b0);
        q.push_back('{e, rdy, rst});
    endfunction
    function automatic void push_fetch(input int fw);
        exp_t e = reset_exp(S_FETCH);
        e.mem_req = 1'b1;
        for (int i = 0; i < fw; i++) push(e, 1'b0);
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        push(e, 1'b1);
    endfunction
    // expected cycle trace of one instruction, from fetch to its last state
    function automatic void build(input int fw, input int mw);
        exp_t e;
        push_fetch(fw);
        e = base(S_DECODE); e.sa = 2'd1; e.sb = 2'd1; e.illegal = !legal(op);
        push(e, 1'($urandom));
        if (op == OP_LOAD || op == OP_STORE) begin
            e = base(S_MEMADR); e.sa = 2'd2; e.sb = 2'd1;
            push(e, 1'($urandom));
            for (int i = 0; i <= mw; i++) begin
                e = base(op == OP_LOAD ? S_MEMREAD : S_MEMWRITE);
                e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = (op == OP_STORE);
                push(e, i == mw);
            end
            if (op == OP_LOAD) begin
                e = base(S_MEMWB); e.rs = 2'd1; e.reg_write = 1'b1;
                push(e, 1'($urandom));
            end
        end else if (op == OP_RTYPE || op == OP_ITYPE) begin
            e = base(op == OP_RTYPE ? S_EXECUTER : S_EXECUTEI);
            e.sa = 2'd2; e.sb = op == OP_RTYPE ? 2'd0 : 2'd1;
            e.alu = funct_alu(funct3, op[5], funct7b5);
            push(e, 1'($urandom));
        end else if (op == OP_BRANCH) begin
            e = base(S_BRANCH); e.sa = 2'd2; e.alu = 3'b010;
            e.pc_write = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero) || (funct3 == 3'b100 && alu_lt);
            push(e, 1'($urandom));
        end else if (op == OP_JAL) begin
            e = base(S_JAL); e.sa = 2'd1; e.sb = 2'd2; e.pc_write = 1'b1;
            push(e, 1'($urandom));
        end
        if (op == OP_RTYPE || op == OP_ITYPE || op == OP_JAL) begin
            e = base(S_ALUWB); e.reg_write = 1'b1;
            push(e, 1'($urandom));
        end
    endfunction
    task automatic flush(input string name);
        exp_t act;
        while (q.size() > 0) begin
            cyc_t c = q.pop_front();
            reset = c.rst;
            mem_ready = c.rdy;
            #1;
            act = {state, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal,
                   alu_src_a, alu_src_b, result_src, imm_src, alu_control};
            vectors++;
            if (act !== c.e) begin
                miscompares++;
                $display("FAIL %s t=%0t: got %h required %h (st,req,adr,mw,ir,pc,rw,ill,sa,sb,rs,imm,alu)",
                         name, $time, act, c.e);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input logic lt, input int fw, input int mw, input string name);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; alu_lt = lt;
        build(fw, mw);
        flush(name);
    endtask
    task automatic test_reset();
        op = OP_JAL;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) push(reset_exp(S_FETCH), 1'b1, 1'b1);
        flush("reset");
    endtask
    task automatic test_load();
        run(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, "lw_ready");
        run(OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b1, 2, 3, "lw_wait");
    endtask
    task automatic test_store();
        run(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3, "sw_wait3");
        run(OP_STORE, 3'b010, 1'b1, 1'b1, 1'b0, 1, 0, "sw_ready");
    endtask
    task automatic test_branch();
        run(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, "beq_taken");
        run(OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1, 0, 0, "beq_not");
        run(OP_BRANCH, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, "bne_taken");
        run(OP_BRANCH, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0, "blt_taken");
        run(OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b1, 0, 0, "f3_010_not");
    endtask
    task automatic test_alu();
        run(OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, "sub");
        run(OP_RTYPE, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "add");
        run(OP_ITYPE, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, "addi_f7");
        run(OP_RTYPE, 3'b101, 1'b1, 1'b0, 1'b0, 0, 0, "sra");
        run(OP_ITYPE, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0, "andi");
        run(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0, "jal");
    endtask
    task automatic test_illegal();
        run(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "illegal");
    endtask
    task automatic test_reset_mid_write();
        exp_t e;
        op = OP_STORE; funct3 = 3'b010; funct7b5 = 1'b0;
        push_fetch(0);
        e = base(S_DECODE); e.sa = 2'd1; e.sb = 2'd1; push(e, 1'b0);
        e = base(S_MEMADR); e.sa = 2'd2; e.sb = 2'd1; push(e, 1'b0);
        e = base(S_MEMWRITE); e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1;
        push(e, 1'b0);
        push(e, 1'b0);
        push(reset_exp(S_MEMWRITE), 1'b0, 1'b1);
        push(reset_exp(S_FETCH), 1'b0, 1'b1);
        flush("reset_mid_sw");
        run(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, "lw_after_reset");
    endtask
    task automatic test_back_to_back();
        logic [6:0] o;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: o = OP_LOAD;
                1: o = OP_STORE;
                2: o = OP_RTYPE;
                3: o = OP_ITYPE;
                4: o = OP_BRANCH;
                5: o = OP_JAL;
                default: do o = 7'($urandom); while (legal(o));
            endcase
            run(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask
    initial begin
        test_reset();
        test_load();
        test_store();
        test_branch();
        test_alu();
        test_illegal();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state changes on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: op  input  7  instruction opcode; funct3  input  3; funct7b5  input  1 (instr[30]).
REQ-004 SHALL have: zero  input  1  ALU result zero; alu_lt  input  1  ALU subtract result negative (signed rs1<rs2).
REQ-005 SHALL have: mem_ready  input  1  memory completes current access this cycle.
REQ-006 SHALL have: mem_req  output  1; adr_src  output  1 (0=PC, 1=ALU result reg); mem_write  output  1; ir_write  output  1; pc_write  output  1; reg_write  output  1.
REQ-007 SHALL have: alu_src_a  output  2 (00=PC, 01=oldPC, 10=rs1); alu_src_b  output  2 (00=rs2, 01=imm, 10=const 4); result_src  output  2 (00=ALU out reg, 01=mem data, 10=ALU result).
REQ-008 SHALL have: alu_control  output  3  ALU operation; imm_src  output  2 (00=I, 01=S, 10=B, 11=J); illegal  output  1  one-cycle pulse; state  output  4  debug.

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-010 FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10; ir_write and pc_update =1 only in cycle mem_ready=1; stay in FETCH while mem_ready=0.
REQ-011 DECODE: src_a=01, src_b=01, alu_op=00 (branch target); next by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, other->FETCH with illegal=1 for that cycle.
REQ-012 MEMADR: src_a=10, src_b=01, alu_op=00; op[5]=0->MEMREAD, op[5]=1->MEMWRITE.
REQ-013 MEMREAD: mem_req=1, adr_src=1; wait for mem_ready, then MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-014 MEMWRITE: mem_req=1, adr_src=1, mem_write=1 held until mem_ready cycle inclusive -> FETCH.
REQ-015 EXECUTER: src_a=10, src_b=00, alu_op=10 -> ALUWB. EXECUTEI: src_a=10, src_b=01, alu_op=10 -> ALUWB.
REQ-016 ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-017 BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00; taken = (funct3=000 & zero) | (funct3=001 & ~zero) | (funct3=100 & alu_lt); other funct3 never taken -> FETCH.
REQ-018 JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
REQ-019 pc_write = pc_update | (BRANCH & taken); mem_ready ignored outside FETCH/MEMREAD/MEMWRITE.
REQ-020 alu_control SHALL be derived combinationally from alu_op, funct3, op[5], funct7b5: 00->000 add, 01->010 sub, 10-> funct3 001->001, 100->100, 101->101, 110->110, 111->111, 000->010 if op[5]&funct7b5 else 000, other->000.
REQ-021 imm_src combinational from op: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-022 Unlisted output fields in any state SHALL be 0; every multi-cycle wait holds all outputs stable.

Reset
REQ-023 reset=1 at a clock edge SHALL force state=FETCH, irrespective of current state (incl. mid-MEMWRITE wait).
REQ-024 While reset=1, mem_req, mem_write, ir_write, pc_write, reg_write, illegal SHALL be 0; other outputs take FETCH values.

Structure
REQ-025 State encodings, opcode constants and alu_op codes SHALL live in a shared constants package/include.
REQ-026 alu_control generation SHALL be an instance of the existing alu_decoder sub-module; FSM next-state and output logic stay in this module.

Verification
REQ-027 lw (op=0000011), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5, result_src=01.
REQ-028 sw with mem_ready low 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, then FETCH; no reg_write.
REQ-029 beq funct3=000: zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; blt funct3=100, alu_lt=1 -> taken; funct3=010 -> not taken.
REQ-030 sub R-type (funct3=000, funct7b5=1) -> alu_control=010 in EXECUTER; addi with funct7b5=1 -> alu_control=000 in EXECUTEI.
REQ-031 op=1111111 -> illegal=1 one cycle in DECODE, next state FETCH, no write enables.
REQ-032 reset asserted during MEMWRITE wait -> next cycle state=FETCH, mem_write=0 while reset high.
